seq_addsub: RTL
===============

// Module: seq_addsub
// PURPOSE
//  Multi-cycle wide adder/subtractor. Adds or subtracts two WORD_BYTES*SLICE_W-bit
//  operands one SLICE_W-bit slice per clock through a single slice adder and a
//  registered carry. Used for CPU-side 16/32-bit arithmetic where one 8-bit
//  slice per cycle is cheaper than a full-width carry chain.
//  Provides carry-out and signed overflow; flags are optional.
// PARAMETERS
//  WORD_BYTES  4  number of slices per operand (>=1)
//  SLICE_W     8  slice width in bits (>=2); W = WORD_BYTES*SLICE_W
// PORTS
//  clk      in   1  clock, rising edge
//  rst_n    in   1  asynchronous reset, active low
//  start    in   1  request; accepted only when ready=1
//  sub      in   1  0: r=a+b+c_in ; 1: r=a+~b+c_in (c_in=1 gives plain a-b)
//  c_in     in   1  carry/no-borrow in, sampled with start
//  a        in   W  operand A, sampled with start
//  b        in   W  operand B, sampled with start
//  ready    out  1  1 in IDLE only
//  done     out  1  one-cycle pulse: r/c_out/v_out valid
//  r        out  W  result
//  c_out    out  1  carry out of bit W-1 (sub: 1 = no borrow)
//  v_out    out  1  signed overflow = carry into bit W-1 XOR carry out of bit W-1
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, slice index=0, carry reg=0, r=0,
//    c_out=0, v_out=0, done=0, ready=1. Operand regs cleared.
//  - FSM IDLE -> RUN -> DONE -> IDLE.
//    IDLE: ready=1. start=1 at edge: latch a, b^{W{sub}}, c_in into regs; idx=0;
//      go to RUN. start=0: stay.
//    RUN: each edge computes slice idx: {cy,s}=A[idx]+B'[idx]+carry; r[idx]<=s;
//      carry<=cy. On last slice (idx=WORD_BYTES-1) also latch c_out=cy and
//      v_out=carry into MSB XOR cy; go to DONE. Else idx<=idx+1.
//    DONE: done=1 for exactly this cycle; ready=0; next edge -> IDLE.
//  - Latency: start accepted at edge k -> done high in the cycle after edge
//    k+WORD_BYTES; ready high again after edge k+WORD_BYTES+1. Throughput:
//    one op per WORD_BYTES+2 cycles.
//  - start while ready=0 (RUN or DONE) is ignored, not queued.
//  - a, b, sub, c_in changes after acceptance have no effect.
//  - r, c_out, v_out hold their values from done until the next start is
//    accepted. During RUN, r holds partial results (low slices updated, high
//    slices stale). r is not cleared at start.
//  - All arithmetic is unsigned modulo 2^W. Only v_out gives signed info.
//  - WORD_BYTES=1: single RUN cycle, done one edge after it.
//  - rst_n asserted mid-RUN/DONE: op aborted, all outputs at reset values
//    immediately, no done pulse. First start after release behaves normally.
// CONFIGURATION
//  SEQ_ADDSUB_FLAGS_EN defined: adds outputs z_out (1: r==0) and n_out (=r[W-1]).
//    Both are registered, updated together with c_out/v_out on the last slice,
//    and 0 in reset. z_out is the AND of per-slice zero bits accumulated
//    during RUN, not a W-wide compare.
//  Not defined: ports z_out/n_out and their logic are absent. Everything else
//    is identical.
// TESTING (WORD_BYTES=4, SLICE_W=8 unless stated)
//  1 a=0x000000FF b=0x00000001 sub=0 c_in=0 -> r=0x00000100 c=0 v=0; done at
//    exactly edge k+4, ready at k+5
//  2 a=0xFFFFFFFF b=0x00000001 sub=0 c_in=0 -> r=0 c=1 v=0 (z=1 n=0 if FLAGS_EN)
//  3 a=0x80000000 b=0x00000001 sub=1 c_in=1 -> r=0x7FFFFFFF c=1 v=1; a=1 b=2
//    sub=1 c_in=1 -> r=0xFFFFFFFF c=0 v=0 (n=1)
//  4 start pulsed every cycle with changing a/b during RUN -> only the first
//    op is executed; result matches first operands; one done pulse
//  5 rst_n low during RUN (idx=2) -> r=0 c=v=done=0 at once, ready=1; after
//    release a=5 b=3 sub=0 c_in=0 -> r=8
//  6 WORD_BYTES=1: a=0x7F b=0x01 -> r=0x80 c=0 v=1; done one edge after RUN

Source files
------------

// File: rtl/seq_addsub_if.sv
// Operand/result bundle for seq_addsub; W must equal WORD_BYTES*SLICE_W of the attached core.
// z_out/n_out exist only when SEQ_ADDSUB_FLAGS_EN is defined.
interface seq_addsub_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic         sub;
  logic         c_in;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         done;
  logic [W-1:0] r;
  logic         c_out;
  logic         v_out;
`ifdef SEQ_ADDSUB_FLAGS_EN
  logic         z_out;
  logic         n_out;
`endif

  modport master (
    output start, sub, c_in, a, b,
`ifdef SEQ_ADDSUB_FLAGS_EN
    input  z_out, n_out,
`endif
    input  ready, done, r, c_out, v_out
  );

  modport slave (
    input  start, sub, c_in, a, b,
`ifdef SEQ_ADDSUB_FLAGS_EN
    output z_out, n_out,
`endif
    output ready, done, r, c_out, v_out
  );
endinterface

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one SLICE_W-bit slice per clock through a single slice adder.
// Define SEQ_ADDSUB_FLAGS_EN to add registered zero (z_out) and negative (n_out) flags.
module seq_addsub #(
  parameter int unsigned WORD_BYTES = 4,
  parameter int unsigned SLICE_W    = 8
) (
  input logic        clk,
  input logic        rst_n,
  seq_addsub_if.slave bus
);
  localparam int unsigned W     = WORD_BYTES * SLICE_W;
  localparam int unsigned IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   idx;
  logic               carry;
  logic [W-1:0]       a_q, b_q, r_q;
  logic               c_q, v_q;
  logic [SLICE_W-1:0] a_sl, b_sl;
  logic [SLICE_W:0]   sum;
  logic               c_msb;
  logic               last, accept;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (idx == IDX_W'(WORD_BYTES - 1));

  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < WORD_BYTES; i++) begin
      if (idx == IDX_W'(i)) begin
        a_sl = a_q[i*SLICE_W +: SLICE_W];
        b_sl = b_q[i*SLICE_W +: SLICE_W];
      end
    end
    sum   = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE_W{1'b0}}, carry};
    // Carry into the MSB is recovered from the MSB sum bit rather than a second adder.
    c_msb = a_sl[SLICE_W-1] ^ b_sl[SLICE_W-1] ^ sum[SLICE_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = RUN;
      RUN:     if (last)      state_nx = DONE;
      DONE:                   state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      carry <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b ^ {W{bus.sub}};
      carry <= bus.c_in;
      idx   <= '0;
    end else if (state == RUN) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (idx == IDX_W'(i)) r_q[i*SLICE_W +: SLICE_W] <= sum[SLICE_W-1:0];
      end
      carry <= sum[SLICE_W];
      if (last) begin
        c_q <= sum[SLICE_W];
        v_q <= c_msb ^ sum[SLICE_W];
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

  assign bus.ready = (state == IDLE);
  assign bus.done  = (state == DONE);
  assign bus.r     = r_q;
  assign bus.c_out = c_q;
  assign bus.v_out = v_q;

`ifdef SEQ_ADDSUB_FLAGS_EN
  logic z_acc, z_q, n_q;

  // Zero flag is the AND of per-slice zero bits gathered as slices complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_acc <= 1'b0;
      z_q   <= 1'b0;
      n_q   <= 1'b0;
    end else if (accept) begin
      z_acc <= 1'b1;
    end else if (state == RUN) begin
      z_acc <= z_acc & (sum[SLICE_W-1:0] == '0);
      if (last) begin
        z_q <= z_acc & (sum[SLICE_W-1:0] == '0);
        n_q <= sum[SLICE_W-1];
      end
    end
  end

  assign bus.z_out = z_q;
  assign bus.n_out = n_q;
`endif
endmodule
